// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: scheduler state encoding, engine constants
// and an index-width helper.
package cnn_pkg;

  localparam int KERNEL_TAPS = 25;
  localparam int CONV2D_LAT  = 7;
  localparam int ROM_RD_LAT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LOAD,
    SCAN,
    DRAIN,
    DONE
  } conv_sched_state_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Window-issue and result-tag bus between conv_sched and the fetch unit / result sink.
// The scheduler is the master; hold flows back from the fetch side.
interface conv_sched_if
  import cnn_pkg::*;
#(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int NUM_KERNELS = 6
);

  localparam int RW = addr_w(IMG_H);
  localparam int CW = addr_w(IMG_W);
  localparam int KW = addr_w(NUM_KERNELS);

  logic          hold;
  logic          win_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          res_valid;
  logic [KW-1:0] res_kernel;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;

  modport master (
    input  hold,
    output win_valid, win_row, win_col,
    output res_valid, res_kernel, res_row, res_col
  );

  modport slave (
    output hold,
    input  win_valid, win_row, win_col,
    input  res_valid, res_kernel, res_row, res_col
  );

endinterface

// File: rtl/conv_sched_tag_pipe.sv
// Fixed-depth valid/row/col delay line that re-times window coordinates onto engine results.
// Latency DEPTH cycles, no backpressure: bubbles travel through as valid=0.
module conv_sched_tag_pipe #(
  parameter int DEPTH = 8,
  parameter int RW    = 5,
  parameter int CW    = 5
) (
  input  logic          cnn_clk,
  input  logic          cnn_rst,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  output logic          out_valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col
);

  logic [DEPTH-1:0] vld_q;
  logic [RW-1:0]    row_q [DEPTH];
  logic [CW-1:0]    col_q [DEPTH];

  always_ff @(posedge cnn_clk) begin
    if (cnn_rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      row_q[0] <= in_row;
      col_q[0] <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        row_q[i] <= row_q[i-1];
        col_q[i] <= col_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_row   = row_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Kernel load / window scan sequencer for the 5x5 conv2d engine; results tagged WIN_LAT+CONV_LAT after issue.
// hold stalls window issue only; CONV_SCHED_PERF_EN adds busy-cycle and stall counters.
module conv_sched
  import cnn_pkg::*;
#(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int K           = 5,
  parameter int NUM_KERNELS = 6,
  parameter int WIN_LAT     = 1,
  parameter int CONV_LAT    = CONV2D_LAT,
  localparam int WA_W       = addr_w(NUM_KERNELS * KERNEL_TAPS),
  localparam int BA_W       = addr_w(NUM_KERNELS),
  localparam int RW         = addr_w(IMG_H),
  localparam int CW         = addr_w(IMG_W)
) (
  input  logic            cnn_clk,
  input  logic            cnn_rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [WA_W-1:0] w_addr,
  input  logic [15:0]     w_data,
  output logic [BA_W-1:0] b_addr,
  input  logic [15:0]     b_data,
  output logic            weight_en,
  output logic [15:0]     weight,
  output logic [15:0]     bias,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls,
`endif
  conv_sched_if.master    sif
);

  localparam int DEPTH = WIN_LAT + CONV_LAT;
  localparam int DW    = addr_w(DEPTH);

  localparam logic [4:0]      J_END    = 5'(KERNEL_TAPS);
  localparam logic [4:0]      J_SAT    = 5'(KERNEL_TAPS - 1);
  localparam logic [4:0]      J_BIAS   = 5'(ROM_RD_LAT - 1);
  localparam logic [BA_W-1:0] K_LAST   = BA_W'(NUM_KERNELS - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - K);
  localparam logic [DW-1:0]   D_LAST   = DW'(DEPTH - 1);
  localparam logic [WA_W-1:0] TAPS     = WA_W'(KERNEL_TAPS);

  conv_sched_state_t state, state_n;

  logic [BA_W-1:0] k;
  logic [4:0]      j;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [DW-1:0]   d;
  logic            issue, last_win, j_done, d_done;

  assign issue    = (state == SCAN) && !sif.hold;
  assign last_win = (row == ROW_LAST) && (col == COL_LAST);
  assign j_done   = (j == J_END);
  assign d_done   = (d == D_LAST);

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign weight_en     = (state == LOAD);
  assign weight        = w_data;
  assign b_addr        = k;
  assign w_addr        = WA_W'(k) * TAPS + WA_W'((j > J_SAT) ? J_SAT : j);
  assign sif.win_valid = issue;
  assign sif.win_row   = row;
  assign sif.win_col   = col;
  assign sif.res_kernel = k;

  always_ff @(posedge cnn_clk) begin
    if (cnn_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = PREP;
      PREP:    state_n = LOAD;
      LOAD:    if (j_done) state_n = SCAN;
      SCAN:    if (issue && last_win) state_n = DRAIN;
      DRAIN:   if (d_done) state_n = (k == K_LAST) ? DONE : PREP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // k only advances once DRAIN has emptied the tag pipe, so res_kernel never mixes kernels.
  always_ff @(posedge cnn_clk) begin
    if (cnn_rst) begin
      k    <= '0;
      j    <= '0;
      row  <= '0;
      col  <= '0;
      d    <= '0;
      bias <= '0;
    end else begin
      case (state)
        IDLE: if (start) k <= '0;
        LOAD: begin
          j <= j_done ? 5'd0 : j + 5'd1;
          if (j == J_BIAS) bias <= b_data;
        end
        SCAN: if (issue) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          d <= d_done ? '0 : d + 1'b1;
          if (d_done && (k != K_LAST)) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  conv_sched_tag_pipe #(
    .DEPTH (DEPTH),
    .RW    (RW),
    .CW    (CW)
  ) u_tag_pipe (
    .cnn_clk   (cnn_clk),
    .cnn_rst   (cnn_rst),
    .in_valid  (issue),
    .in_row    (row),
    .in_col    (col),
    .out_valid (sif.res_valid),
    .out_row   (sif.res_row),
    .out_col   (sif.res_col)
  );

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge cnn_clk) begin
    if (cnn_rst || (state == IDLE && start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (state == SCAN && sif.hold) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched: a phase-level schedule model predicts every cycle,
// and an issue log indexed by cycle predicts the tagged results.
module tb_conv_sched;
  import cnn_pkg::*;

  localparam int NK   = 2;
  localparam int IW   = 28;
  localparam int IH   = 28;
  localparam int WPR  = IW - 4;
  localparam int NWIN = (IH - 4) * WPR;
  localparam int DEP  = 8;
  localparam int WA_W = addr_w(NK * KERNEL_TAPS);
  localparam int BA_W = addr_w(NK);

  logic            cnn_clk = 1'b0;
  logic            cnn_rst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, weight_en;
  logic [WA_W-1:0] w_addr;
  logic [BA_W-1:0] b_addr;
  logic [15:0]     w_data, b_data, weight, bias;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]     perf_cycles, perf_stalls;
`endif

  conv_sched_if #(.IMG_W(IW), .IMG_H(IH), .NUM_KERNELS(NK)) sif ();

  conv_sched #(
    .IMG_W(IW), .IMG_H(IH), .K(5), .NUM_KERNELS(NK), .WIN_LAT(1), .CONV_LAT(7)
  ) dut (
    .cnn_clk   (cnn_clk),
    .cnn_rst   (cnn_rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .weight_en (weight_en),
    .weight    (weight),
    .bias      (bias),
`ifdef CONV_SCHED_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
`endif
    .sif       (sif)
  );

  always #5 cnn_clk = ~cnn_clk;

  int cyc = 0;
  always @(posedge cnn_clk) cyc <= cyc + 1;

  // ROMs with one-cycle read latency: weight = address, bias = 0xB000 | kernel.
  always @(posedge cnn_clk) begin
    w_data <= 16'(w_addr);
    b_data <= 16'hb000 | 16'(b_addr);
  end

  bit exp_v [16384];
  int exp_r [16384];
  int exp_c [16384];
  int exp_k [16384];
  bit tag_on = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic tick(input logic h, input logic s);
    @(negedge cnn_clk);
    sif.hold = h;
    start = s;
    #1;
    exp_v[cyc] = 1'b0;
  endtask

  function automatic logic rh(input bit en);
    return en && ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic sr(input bit en, input int t);
    return (t == 100) || (en && ($urandom_range(0, 15) == 0));
  endfunction

  always @(negedge cnn_clk) begin
    #2;
    if (tag_on && cyc >= DEP) begin
      chk("res_valid", sif.res_valid, exp_v[cyc-DEP]);
      if (exp_v[cyc-DEP]) begin
        chk("res_row", sif.res_row, exp_r[cyc-DEP]);
        chk("res_col", sif.res_col, exp_c[cyc-DEP]);
        chk("res_kernel", sif.res_kernel, exp_k[cyc-DEP]);
      end
    end
  end

  task automatic zero_chk();
    chk("z_busy", busy, 0);
    chk("z_done", done, 0);
    chk("z_wen", weight_en, 0);
    chk("z_winv", sif.win_valid, 0);
    chk("z_resv", sif.res_valid, 0);
    chk("z_waddr", w_addr, 0);
    chk("z_baddr", b_addr, 0);
    chk("z_bias", bias, 0);
    chk("z_wrow", sif.win_row, 0);
    chk("z_wcol", sif.win_col, 0);
    chk("z_rk", sif.res_kernel, 0);
    chk("z_rrow", sif.res_row, 0);
    chk("z_rcol", sif.res_col, 0);
`ifdef CONV_SCHED_PERF_EN
    chk("z_pcyc", perf_cycles, 0);
    chk("z_pstl", perf_stalls, 0);
`endif
  endtask

  // Reset in the current cycle: windows issued in the last DEP cycles must never surface.
  task automatic abort_run();
    cnn_rst = 1'b1;
    for (int i = 0; i < DEP; i++) exp_v[cyc-i] = 1'b0;
    tick(1'b0, 1'b0);
    cnn_rst = 1'b0;
    zero_chk();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 0);
    end
  endtask

  task automatic run(input int rst_at, input bit rnd, input bit force10);
    int t, n, stalls, busy_n, fl;
    logic h;
    t = 0; stalls = 0; busy_n = 0;
    fl = force10 ? 10 : 0;
    tick(rh(rnd), 1'b1);
    chk("st_busy", busy, 0);
    for (int k = 0; k < NK; k++) begin
      t++; tick(rh(rnd), sr(rnd, t)); busy_n++;
      chk("prep_busy", busy, 1);
      chk("prep_wen", weight_en, 0);
      chk("prep_baddr", b_addr, k);
      chk("prep_winv", sif.win_valid, 0);
      if (t == rst_at) begin abort_run(); return; end
      for (int j = 0; j <= 25; j++) begin
        t++; tick(rh(rnd), sr(rnd, t)); busy_n++;
        chk("load_wen", weight_en, 1);
        chk("load_waddr", w_addr, k * 25 + ((j < 24) ? j : 24));
        chk("load_winv", sif.win_valid, 0);
        if (j >= 1) begin
          chk("load_weight", weight, k * 25 + j - 1);
          chk("load_bias", bias, 32'hb000 | k);
        end
        if (t == rst_at) begin abort_run(); return; end
      end
      n = 0;
      while (n < NWIN) begin
        t++;
        if (fl > 0 && n == 3 * WPR + 7) begin
          h = 1'b1;
          fl--;
        end else begin
          h = rnd && ($urandom_range(0, 7) == 0);
        end
        tick(h, sr(rnd, t)); busy_n++;
        if (h) stalls++;
        chk("scan_winv", sif.win_valid, !h);
        chk("scan_row", sif.win_row, n / WPR);
        chk("scan_col", sif.win_col, n % WPR);
        chk("scan_wen", weight_en, 0);
        chk("scan_done", done, 0);
        if (!h) begin
          exp_v[cyc] = 1'b1;
          exp_r[cyc] = n / WPR;
          exp_c[cyc] = n % WPR;
          exp_k[cyc] = k;
          n++;
        end
        if (t == rst_at) begin abort_run(); return; end
      end
      for (int i = 0; i < DEP; i++) begin
        t++; tick(rh(rnd), sr(rnd, t)); busy_n++;
        chk("drain_winv", sif.win_valid, 0);
        chk("drain_done", done, 0);
        chk("drain_busy", busy, 1);
        if (t == rst_at) begin abort_run(); return; end
      end
    end
    t++; tick(rh(rnd), sr(rnd, t)); busy_n++;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    tick(rh(rnd), 1'b0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_cycles", perf_cycles, busy_n);
    chk("perf_stalls", perf_stalls, stalls);
`endif
  endtask

  initial begin
    sif.hold = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    cnn_rst = 1'b0;
    tick(1'b0, 1'b0);
    zero_chk();
    tag_on = 1'b1;
    run(-1, 1'b1, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    run(300, 1'b1, 1'b0);
    run(-1, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencing controller for the 5x5 `conv2d` engine in the MNIST CNN pipeline.
- For each of `NUM_KERNELS` kernels it reads the bias and 25 weights from ROM and drives the engine's `weight_en`/`weight`/`bias` load protocol.
- It then scans every valid window position of the input feature map, issuing one window coordinate per cycle to the window fetch unit.
- It tags each engine output with its kernel, row and column after the fixed pipeline latency.
- It waits for the engine pipeline to drain before reloading weights, so no in-flight window is ever computed with mixed weights.

## Interface
Parameters:
- `IMG_W`, 28: input width in pixels.
- `IMG_H`, 28: input height in pixels.
- `K`, 5: kernel size. Fixed by the engine; must be 5.
- `NUM_KERNELS`, 6: number of kernels processed per `start`.
- `WIN_LAT`, 1: cycles from `win_valid` until the matching rows reach the engine inputs.
- `CONV_LAT`, 7: engine latency from rows-at-input to `norm_result`.

Ports (clock and reset first):
- `cnn_clk` in 1: clock.
- `cnn_rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run. Ignored while `busy`.
- `hold` in 1: stalls window issue only.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the run completes.
- `w_addr` out $clog2(NUM_KERNELS*25): weight ROM address. ROM read latency is 1 cycle.
- `w_data` in 16: weight ROM data.
- `b_addr` out $clog2(NUM_KERNELS): bias ROM address. ROM read latency is 1 cycle.
- `b_data` in 16: bias ROM data.
- `weight_en` out 1: engine load enable.
- `weight` out 16: engine weight, combinational pass-through of `w_data`.
- `bias` out 16: engine bias, registered.
- `win_valid` out 1: window coordinate valid.
- `win_row` out $clog2(IMG_H): window top-left row.
- `win_col` out $clog2(IMG_W): window top-left column.
- `res_valid` out 1: `norm_result` is valid this cycle.
- `res_kernel` out $clog2(NUM_KERNELS): kernel index of the current result.
- `res_row` out $clog2(IMG_H): result row.
- `res_col` out $clog2(IMG_W): result column.

## Operation
- FSM states: IDLE, PREP, LOAD, SCAN, DRAIN, DONE.
- IDLE: when `start` is asserted, set kernel index `k` to 0 and go to PREP.
- PREP (1 cycle): drive `b_addr=k`. Register `bias<=b_data` on the first LOAD cycle; `bias` then holds for the rest of LOAD.
- LOAD (26 cycles, counter j=0..25):
  - `weight_en=1`.
  - `w_addr=k*25+j`, with j saturating at 24.
  - `weight=w_data`, so at cycle j≥1 the engine sees weight index j-1. The value at j=0 is don't-care; the engine discards it.
  - After j=25, go to SCAN.
- `weight_en` must fall for at least one cycle between kernels, because the engine resets its load address on low.
- SCAN:
  - Issues `(IMG_H-K+1)*(IMG_W-K+1)` windows (576 at defaults) in raster order: `win_col` increments fastest and wraps at `IMG_W-K`.
  - `win_valid=1` when `!hold`.
  - When `hold=1`: `win_valid=0` and the coordinate freezes.
  - After the last window is issued, go to DRAIN.
- DRAIN: wait `WIN_LAT+CONV_LAT` cycles. Then:
  - if `k<NUM_KERNELS-1`: `k++` and go to PREP;
  - otherwise go to DONE.
- DONE (1 cycle): `done=1`, `busy=0` next cycle, return to IDLE.
- Result tagging:
  - A shift register of depth `WIN_LAT+CONV_LAT` carries {valid,row,col}.
  - `res_kernel` is `k`. It is stable because DRAIN covers the full depth.
  - Bubbles caused by `hold` propagate as `res_valid=0`.
- `start` while busy: ignored, with no effect on counters.
- `cnn_rst` mid-run:
  - next state IDLE, all counters cleared, shift register cleared;
  - no `done` pulse;
  - engine results already in flight are not tagged.

## Timing
- Reset values: `busy`, `done`, `weight_en`, `win_valid`, `res_valid` are 0; every address, `bias`, coordinate and tag is 0.
- `start` accepted at cycle 0 → PREP at cycle 1 → first `weight_en` at cycle 2 → first `win_valid` at cycle 28, with no hold.
- A window issued at cycle t yields `res_valid` at cycle t+`WIN_LAT`+`CONV_LAT` (t+8 at defaults).
- Kernel period with no hold: 1+26+576+8 = 611 cycles. A full 6-kernel run issues `done` at cycle 3666+1 after start.
- `hold` is sampled in the same cycle; it has no effect outside SCAN.

## Configuration
- `CONV_SCHED_PERF_EN` defined:
  - adds output `perf_cycles` (32 bits), counting cycles with `busy=1`;
  - adds output `perf_stalls` (32 bits), counting SCAN cycles with `hold=1`;
  - both clear on an accepted `start` and on `cnn_rst`, and hold their value after `done`.
- Undefined: neither port nor counter exists.

## Structure
- Shared package `cnn_pkg` holds:
  - the state enum `conv_sched_state_t`;
  - constants `KERNEL_TAPS=25`, `CONV2D_LAT=7`, `ROM_RD_LAT=1`.
- One natural sub-module, `conv_sched_tag_pipe`: a parameterised-depth valid/row/col delay line used for result tagging.

## Test plan
- Reset, then `start`: `weight_en` is high for exactly cycles 2..27. `w_addr` runs 0..24. `bias` equals ROM[b 0] from cycle 3.
- ROM weights = index value: `weight` at LOAD cycle j equals j-1 for j=1..25.
- No hold, `NUM_KERNELS=1`:
  - 576 `win_valid` pulses, first coordinate (0,0), last (23,23);
  - `res_valid` count is 576, each tag equal to the issued coordinate 8 cycles earlier;
  - `done` at cycle 612.
- `hold` high for 10 cycles mid-scan at window (3,7): coordinate freezes at (3,7), 10 `res_valid` bubbles appear, and `done` is delayed by 10 cycles.
- `start` pulsed at cycle 100 of a run: no change to `done` timing. `cnn_rst` at cycle 300: all outputs 0 next cycle, and no `done` pulse.
- `CONV_SCHED_PERF_EN` with the 10-cycle hold above: `perf_stalls=10`, `perf_cycles=622`.
